mc_ctrl_unit: RTL and testbench
===============================

Name: mc_ctrl_unit

Overview:
- Multi-cycle CPU control FSM; drives the 3-bit ALU operation code and the datapath enables.
- It is the producer of `alu_op`; the shared ALU is the consumer and returns `zf`/`of` to this block.
- Sits between the instruction register (`op`/`funct`) and the datapath muxes and enables.
- Sequences FETCH → DECODE → execute → memory → writeback, one state per clock.

Parameters:
- RESET_PC_HOLD, 1, cycles spent in IDLE after `rst` deasserts before the first FETCH (1..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  6  instruction bits [31:26], valid from the cycle after FETCH.
- funct  in  6  instruction bits [5:0].
- zf  in  1  ALU zero flag, combinational from the current `alu_op` and operands.
- of  in  1  ALU overflow flag, meaningful only for ADD/SUB.
- alu_op  out  3  ALU operation code: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLT (unsigned A<B), 111 SHL (B<<A).
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended imm16, 11 = sign-extended imm16 << 2.
- pc_en  out  1  PC load enable.
- pc_src  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
- ir_we  out  1  instruction register write.
- mem_we  out  1  data memory write.
- iord  out  1  memory address: 0 = PC, 1 = ALUOut.
- reg_we  out  1  register file write.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- exc  out  1  exception flag (illegal opcode or trapped overflow).
- state  out  4  current state code, for debug.

Behaviour:
Reset and output style:
- `rst` on a rising edge forces IDLE. All outputs decode to 0 in IDLE, including `alu_op`=000 and `state`=0.
- Reset mid-instruction aborts it; no partial writes occur after that edge.
- Outputs are a Moore decode of `state` and the latched `op`/`funct`. The only exception is `pc_en` in BRANCH, which also depends on `zf`.

States (code: action):
- IDLE (0): counts RESET_PC_HOLD cycles, then goes to FETCH.
- FETCH (1): `iord`=0, `ir_we`=1, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=ADD, `pc_src`=00, `pc_en`=1. Next state DECODE.
- DECODE (2): registers `op`/`funct` internally. `alu_src_a`=0, `alu_src_b`=11, `alu_op`=ADD (branch target into ALUOut). Dispatch on `op`:
  - 000000 → EXEC_R
  - 100011 / 101011 → MEM_ADDR
  - 000100 / 000101 → BRANCH
  - 000010 → JUMP
  - 001000 / 001100 / 001101 / 001110 → EXEC_I
  - any other opcode → TRAP
- EXEC_R (3): `alu_src_a`=1, `alu_src_b`=00. `alu_op` from `funct`:
  - 100000 → ADD, 100010 → SUB, 100100 → AND, 100101 → OR
  - 100110 → XOR, 100111 → NOR, 101011 → SLT, 000100 → SHL
  - any other `funct` → TRAP (no write)
  - Next state WB_R.
- WB_R (4): `reg_we`=1, `reg_dst`=1, `mem_to_reg`=0. Next state FETCH.
- EXEC_I (5): `alu_src_a`=1, `alu_src_b`=10. `alu_op`: addi → ADD, andi → AND, ori → OR, xori → XOR. Next state WB_I.
- WB_I (6): `reg_we`=1, `reg_dst`=0. Next state FETCH.
- MEM_ADDR (7): `alu_src_a`=1, `alu_src_b`=10, ADD. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD (8): `iord`=1. Next state WB_MEM.
- WB_MEM (9): `reg_we`=1, `reg_dst`=0, `mem_to_reg`=1. Next state FETCH.
- MEM_WR (10): `iord`=1, `mem_we`=1. Next state FETCH.
- BRANCH (11): `alu_src_a`=1, `alu_src_b`=00, SUB, `pc_src`=01. `pc_en` = `zf` for beq, `~zf` for bne. Next state FETCH.
- JUMP (12): `pc_src`=10, `pc_en`=1. Next state FETCH.
- TRAP (13): `exc`=1, all enables 0. Sticky until `rst`.

Latency (cycles from FETCH):
- R-type 4, I-type ALU 4, lw 5, sw 4, beq/bne 3, j 3.

Other rules:
- `op`/`funct` changing after DECODE has no effect on the current instruction.
- Unused state codes 14 and 15 go to IDLE.

Optional Feature:
- Macro `OVF_TRAP_EN`.
- Defined: in EXEC_R with add/sub, or in EXEC_I with addi, `of`=1 sends the FSM to TRAP instead of the writeback state. No `reg_we` is asserted.
- Not defined: `of` is ignored and the `exc` port exists but is driven only by the illegal-opcode path.

Decomposition:
- Shared package/header holds:
  - the ALU op codes (AND..SHL);
  - the opcode and funct constants;
  - the `alu_src_b` and `pc_src` encodings;
  - the state codes.
- The ALU and its testbench use the same package.
- One natural sub-module, `mc_alu_dec`: combinational map from (state class, `op`, `funct`) to `alu_op` plus an illegal flag.

Test Plan:
- `rst`=1 for 2 cycles, RESET_PC_HOLD=1 → all outputs 0; FETCH reached on the 2nd cycle after release; FETCH shows `alu_op`=100, `alu_src_b`=01, `pc_en`=1, `ir_we`=1.
- R-type `op`=0, `funct`=100010 → `state` sequence 1,2,3,4,1; EXEC_R `alu_op`=101; WB_R `reg_we`=1, `reg_dst`=1.
- lw (100011) then sw (101011) → lw 5 cycles with `reg_we`/`mem_to_reg`=1 only in WB_MEM; sw `mem_we`=1 exactly 1 cycle.
- beq with `zf`=1 → `pc_en`=1, `pc_src`=01 in BRANCH; bne with `zf`=1 → `pc_en`=0.
- `op`=111111 → TRAP, `exc`=1 held 10 cycles; `rst` returns to IDLE with `exc`=0.
- `OVF_TRAP_EN` defined, add with `of`=1 → TRAP, no `reg_we`; without the macro → WB_R with `reg_we`=1.

Source files
------------

// File: rtl/mc_ctrl_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_unit_pkg
// Purpose  : Shared definitions for the multi-cycle control unit and the ALU.
//            The package holds the following:
//              - ALU operation codes
//              - opcode and funct constants
//              - alu_src_b and pc_src encodings
//              - FSM state codes
//              - ALU decode classes
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mc_ctrl_unit_pkg;

  // ALU operation codes
  localparam logic [2:0] c_alu_and = 3'b000;
  localparam logic [2:0] c_alu_or  = 3'b001;
  localparam logic [2:0] c_alu_xor = 3'b010;
  localparam logic [2:0] c_alu_nor = 3'b011;
  localparam logic [2:0] c_alu_add = 3'b100;
  localparam logic [2:0] c_alu_sub = 3'b101;
  localparam logic [2:0] c_alu_slt = 3'b110;
  localparam logic [2:0] c_alu_shl = 3'b111;

  // Primary opcodes, instruction bits [31:26]
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bne   = 6'b000101;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_andi  = 6'b001100;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_xori  = 6'b001110;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;

  // R-type funct codes, instruction bits [5:0]
  localparam logic [5:0] c_fn_shl = 6'b000100;
  localparam logic [5:0] c_fn_add = 6'b100000;
  localparam logic [5:0] c_fn_sub = 6'b100010;
  localparam logic [5:0] c_fn_and = 6'b100100;
  localparam logic [5:0] c_fn_or  = 6'b100101;
  localparam logic [5:0] c_fn_xor = 6'b100110;
  localparam logic [5:0] c_fn_nor = 6'b100111;
  localparam logic [5:0] c_fn_slt = 6'b101011;

  // ALU B-operand select
  localparam logic [1:0] c_srcb_reg    = 2'b00;
  localparam logic [1:0] c_srcb_four   = 2'b01;
  localparam logic [1:0] c_srcb_imm    = 2'b10;
  localparam logic [1:0] c_srcb_imm_sh = 2'b11;

  // PC source select
  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_WB_R     = 4'd4,
    ST_EXEC_I   = 4'd5,
    ST_WB_I     = 4'd6,
    ST_MEM_ADDR = 4'd7,
    ST_MEM_RD   = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_MEM_WR   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12,
    ST_TRAP     = 4'd13
  } state_t;

  // What kind of ALU operation the current state asks for
  typedef enum logic [2:0] {
    ALU_CLS_NONE  = 3'd0,
    ALU_CLS_ADD   = 3'd1,
    ALU_CLS_SUB   = 3'd2,
    ALU_CLS_RTYPE = 3'd3,
    ALU_CLS_ITYPE = 3'd4
  } alu_cls_t;

endpackage
`default_nettype wire

// File: rtl/mc_alu_dec.sv
`default_nettype none
// ============================================================================
// Module   : mc_alu_dec
// Purpose  : Combinational map from (state class, op, funct) to alu_op.
//            Flags codes that have no ALU meaning as illegal.
// Ports    : cls     in  ALU class requested by the current FSM state
//            op      in  6-bit opcode (latched copy)
//            funct   in  6-bit funct  (latched copy)
//            alu_op  out 3-bit ALU operation code (000 when no op is needed)
//            illegal out 1 when op/funct cannot be mapped for this class
// Revision : 1.0 - initial release
// ============================================================================
module mc_alu_dec
  import mc_ctrl_unit_pkg::*;
(
  input  alu_cls_t   cls,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = c_alu_and;
    illegal = 1'b0;
    case (cls)
      ALU_CLS_ADD: alu_op = c_alu_add;
      ALU_CLS_SUB: alu_op = c_alu_sub;
      ALU_CLS_RTYPE: begin
        case (funct)
          c_fn_add: alu_op = c_alu_add;
          c_fn_sub: alu_op = c_alu_sub;
          c_fn_and: alu_op = c_alu_and;
          c_fn_or:  alu_op = c_alu_or;
          c_fn_xor: alu_op = c_alu_xor;
          c_fn_nor: alu_op = c_alu_nor;
          c_fn_slt: alu_op = c_alu_slt;
          c_fn_shl: alu_op = c_alu_shl;
          default:  illegal = 1'b1;
        endcase
      end
      ALU_CLS_ITYPE: begin
        case (op)
          c_op_addi: alu_op = c_alu_add;
          c_op_andi: alu_op = c_alu_and;
          c_op_ori:  alu_op = c_alu_or;
          c_op_xori: alu_op = c_alu_xor;
          default:   illegal = 1'b1;
        endcase
      end
      default: begin
        alu_op  = c_alu_and;
        illegal = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_unit
// Purpose  : Control FSM for the multi-cycle CPU. Sequences each instruction
//            through FETCH, DECODE, execute, memory and writeback, one state
//            per clock. Outputs are a Moore decode of the state and of the
//            latched op/funct. The one exception is pc_en in BRANCH, which
//            also follows zf.
// Config   : OVF_TRAP_EN - when defined, an ALU overflow (of=1) on add/sub or
//            addi sends the FSM to TRAP instead of writeback.
// Params   : RESET_PC_HOLD - number of IDLE cycles after reset release before
//            the first FETCH (1..3)
// Ports    : clk, rst                   clock / synchronous active-high reset
//            op, funct                  instruction fields from the IR
//            zf, of                     ALU zero / overflow flags
//            alu_op                     ALU operation code
//            alu_src_a, alu_src_b       ALU operand selects
//            pc_en, pc_src              PC load enable / source select
//            ir_we, mem_we, iord        IR write, memory write, address select
//            reg_we, reg_dst            register-file write, destination select
//            mem_to_reg                 register-file write-data select
//            exc                        exception flag (sticky TRAP)
//            state                      current state code, for debug
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_unit
  import mc_ctrl_unit_pkg::*;
#(
  parameter int RESET_PC_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zf,
  input  logic       of,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       ir_we,
  output logic       mem_we,
  output logic       iord,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       exc,
  output logic [3:0] state
);

  localparam logic [1:0] c_hold_last = 2'(RESET_PC_HOLD - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_hold_cnt;
  logic [5:0] r_op;
  logic [5:0] r_funct;
  alu_cls_t   w_cls;
  logic [2:0] w_dec_op;
  logic       w_dec_illegal;
  logic       w_ovf_trap;

  // The live op/funct are captured on the DECODE edge. Every later state
  // works only from these copies, so IR changes cannot disturb the
  // instruction that is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= 2'd0;
      r_op       <= 6'd0;
      r_funct    <= 6'd0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == ST_IDLE) && (w_next_state == ST_IDLE)) begin
        r_hold_cnt <= r_hold_cnt + 2'd1;
      end else begin
        r_hold_cnt <= 2'd0;
      end
      if (r_state == ST_DECODE) begin
        r_op    <= op;
        r_funct <= funct;
      end
    end
  end

  always_comb begin
    w_cls = ALU_CLS_NONE;
    case (r_state)
      ST_FETCH, ST_DECODE, ST_MEM_ADDR: w_cls = ALU_CLS_ADD;
      ST_BRANCH:                        w_cls = ALU_CLS_SUB;
      ST_EXEC_R:                        w_cls = ALU_CLS_RTYPE;
      ST_EXEC_I:                        w_cls = ALU_CLS_ITYPE;
      default:                          w_cls = ALU_CLS_NONE;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .cls     (w_cls),
    .op      (r_op),
    .funct   (r_funct),
    .alu_op  (w_dec_op),
    .illegal (w_dec_illegal)
  );

`ifdef OVF_TRAP_EN
  assign w_ovf_trap = of &
      (((r_state == ST_EXEC_R) && ((r_funct == c_fn_add) || (r_funct == c_fn_sub))) ||
       ((r_state == ST_EXEC_I) && (r_op == c_op_addi)));
`else
  logic w_unused_of;
  assign w_unused_of = of;
  assign w_ovf_trap  = 1'b0;
`endif

  always_comb begin
    w_next_state = ST_IDLE;
    alu_op       = w_dec_op;
    alu_src_a    = 1'b0;
    alu_src_b    = c_srcb_reg;
    pc_en        = 1'b0;
    pc_src       = c_pcsrc_alu;
    ir_we        = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    reg_we       = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    exc          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_state = (r_hold_cnt == c_hold_last) ? ST_FETCH : ST_IDLE;
      end
      ST_FETCH: begin
        ir_we        = 1'b1;
        alu_src_b    = c_srcb_four;
        pc_src       = c_pcsrc_alu;
        pc_en        = 1'b1;
        w_next_state = ST_DECODE;
      end
      ST_DECODE: begin
        // Precompute the branch target into ALUOut while dispatching
        alu_src_b = c_srcb_imm_sh;
        case (op)
          c_op_rtype:                               w_next_state = ST_EXEC_R;
          c_op_lw, c_op_sw:                         w_next_state = ST_MEM_ADDR;
          c_op_beq, c_op_bne:                       w_next_state = ST_BRANCH;
          c_op_j:                                   w_next_state = ST_JUMP;
          c_op_addi, c_op_andi, c_op_ori, c_op_xori: w_next_state = ST_EXEC_I;
          default:                                  w_next_state = ST_TRAP;
        endcase
      end
      ST_EXEC_R: begin
        alu_src_a    = 1'b1;
        alu_src_b    = c_srcb_reg;
        w_next_state = (w_dec_illegal || w_ovf_trap) ? ST_TRAP : ST_WB_R;
      end
      ST_WB_R: begin
        reg_we       = 1'b1;
        reg_dst      = 1'b1;
        w_next_state = ST_FETCH;
      end
      ST_EXEC_I: begin
        alu_src_a    = 1'b1;
        alu_src_b    = c_srcb_imm;
        w_next_state = (w_dec_illegal || w_ovf_trap) ? ST_TRAP : ST_WB_I;
      end
      ST_WB_I: begin
        reg_we       = 1'b1;
        w_next_state = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = c_srcb_imm;
        w_next_state = (r_op == c_op_lw) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        iord         = 1'b1;
        w_next_state = ST_WB_MEM;
      end
      ST_WB_MEM: begin
        reg_we       = 1'b1;
        mem_to_reg   = 1'b1;
        w_next_state = ST_FETCH;
      end
      ST_MEM_WR: begin
        iord         = 1'b1;
        mem_we       = 1'b1;
        w_next_state = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_src_b    = c_srcb_reg;
        pc_src       = c_pcsrc_aluout;
        pc_en        = (r_op == c_op_beq) ? zf : ~zf;
        w_next_state = ST_FETCH;
      end
      ST_JUMP: begin
        pc_src       = c_pcsrc_jump;
        pc_en        = 1'b1;
        w_next_state = ST_FETCH;
      end
      ST_TRAP: begin
        exc          = 1'b1;
        w_next_state = ST_TRAP;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_unit
// Purpose  : Directed self-checking bench for mc_ctrl_unit.
//            Every output is packed into one 20-bit vector:
//              {state, alu_op, alu_src_a, alu_src_b, pc_en, pc_src, ir_we,
//               mem_we, iord, reg_we, reg_dst, mem_to_reg, exc}
//            Each cycle's vector is compared against a hand-written
//            expectation.
// Config   : OVF_TRAP_EN - selects the expected overflow behaviour
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_unit;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [5:0] op    = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zf    = 1'b0;
  logic       of    = 1'b0;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       ir_we;
  logic       mem_we;
  logic       iord;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       exc;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  logic [19:0] obs;
  assign obs = {state, alu_op, alu_src_a, alu_src_b, pc_en, pc_src, ir_we,
                mem_we, iord, reg_we, reg_dst, mem_to_reg, exc};

  mc_ctrl_unit #(.RESET_PC_HOLD(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct      (funct),
    .zf         (zf),
    .of         (of),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .ir_we      (ir_we),
    .mem_we     (mem_we),
    .iord       (iord),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .exc        (exc),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Builds an expected output vector from hand-chosen field values
  function automatic logic [19:0] ev(
    input logic [3:0] st, input logic [2:0] aop, input logic sa,
    input logic [1:0] sb, input logic pe, input logic [1:0] ps,
    input logic irw, input logic mw, input logic io, input logic rw,
    input logic rd, input logic m2r, input logic ex);
    return {st, aop, sa, sb, pe, ps, irw, mw, io, rw, rd, m2r, ex};
  endfunction

  localparam logic [19:0] c_zero   = 20'd0;
  localparam logic [19:0] c_fetch  = {4'd1, 3'b100, 1'b0, 2'b01, 1'b1, 2'b00, 7'b1000000};
  localparam logic [19:0] c_decode = {4'd2, 3'b100, 1'b0, 2'b11, 1'b0, 2'b00, 7'b0000000};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (state !== 4'd1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (state !== 4'd1) begin
      errors++;
      $display("FAIL wait_fetch timeout state=%0d required=1", state);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    wait_fetch();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (obs !== c_zero) begin errors++; $display("FAIL reset_outputs got=%h required=%h", obs, c_zero); end
    rst = 1'b0;
    checks++;
    if (obs !== c_zero) begin errors++; $display("FAIL idle_hold got=%h required=%h", obs, c_zero); end
    step();
    checks++;
    if (obs !== c_fetch) begin errors++; $display("FAIL first_fetch got=%h required=%h", obs, c_fetch); end
  endtask

  task automatic test_rtype();
    logic [19:0] e;
    op = 6'b000000; funct = 6'b100010;
    step();
    checks++;
    if (obs !== c_decode) begin errors++; $display("FAIL rtype_decode got=%h required=%h", obs, c_decode); end
    step();
    e = ev(4'd3, 3'b101, 1'b1, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL rtype_exec got=%h required=%h", obs, e); end
    // Late IR change must not affect the instruction in flight
    op = 6'b111111; funct = 6'b111111;
    step();
    e = ev(4'd4, 3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 0, 0, 0, 1, 1, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL rtype_wb got=%h required=%h", obs, e); end
    step();
    checks++;
    if (obs !== c_fetch) begin errors++; $display("FAIL rtype_refetch got=%h required=%h", obs, c_fetch); end
  endtask

  task automatic test_itype();
    logic [19:0] e;
    op = 6'b001101; funct = 6'b000000;
    step();
    step();
    e = ev(4'd5, 3'b001, 1'b1, 2'b10, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL ori_exec got=%h required=%h", obs, e); end
    step();
    e = ev(4'd6, 3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL ori_wb got=%h required=%h", obs, e); end
    step();
    checks++;
    if (obs !== c_fetch) begin errors++; $display("FAIL ori_refetch got=%h required=%h", obs, c_fetch); end
  endtask

  task automatic test_lw_sw();
    logic [19:0] e;
    op = 6'b100011;
    step();
    step();
    e = ev(4'd7, 3'b100, 1'b1, 2'b10, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL lw_addr got=%h required=%h", obs, e); end
    step();
    e = ev(4'd8, 3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL lw_read got=%h required=%h", obs, e); end
    step();
    e = ev(4'd9, 3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 0, 0, 0, 1, 0, 1, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL lw_wb got=%h required=%h", obs, e); end
    step();
    checks++;
    if (obs !== c_fetch) begin errors++; $display("FAIL lw_refetch got=%h required=%h", obs, c_fetch); end
    op = 6'b101011;
    step();
    step();
    e = ev(4'd7, 3'b100, 1'b1, 2'b10, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL sw_addr got=%h required=%h", obs, e); end
    step();
    e = ev(4'd10, 3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 0, 1, 1, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL sw_write got=%h required=%h", obs, e); end
    step();
    checks++;
    if (obs !== c_fetch) begin errors++; $display("FAIL sw_refetch got=%h required=%h", obs, c_fetch); end
  endtask

  task automatic test_branch();
    logic [19:0] e;
    op = 6'b000100; zf = 1'b1;
    step();
    step();
    e = ev(4'd11, 3'b101, 1'b1, 2'b00, 1'b1, 2'b01, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL beq_taken got=%h required=%h", obs, e); end
    step();
    checks++;
    if (obs !== c_fetch) begin errors++; $display("FAIL beq_refetch got=%h required=%h", obs, c_fetch); end
    op = 6'b000101;
    step();
    step();
    e = ev(4'd11, 3'b101, 1'b1, 2'b00, 1'b0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL bne_not_taken got=%h required=%h", obs, e); end
    zf = 1'b0;
    #1;
    e = ev(4'd11, 3'b101, 1'b1, 2'b00, 1'b1, 2'b01, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL bne_taken got=%h required=%h", obs, e); end
    step();
    checks++;
    if (obs !== c_fetch) begin errors++; $display("FAIL bne_refetch got=%h required=%h", obs, c_fetch); end
  endtask

  task automatic test_jump();
    logic [19:0] e;
    op = 6'b000010;
    step();
    step();
    e = ev(4'd12, 3'b000, 1'b0, 2'b00, 1'b1, 2'b10, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL jump got=%h required=%h", obs, e); end
    step();
    checks++;
    if (obs !== c_fetch) begin errors++; $display("FAIL jump_refetch got=%h required=%h", obs, c_fetch); end
  endtask

  task automatic test_reset_abort();
    op = 6'b101011;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (obs !== c_zero) begin errors++; $display("FAIL abort_sw got=%h required=%h", obs, c_zero); end
    rst = 1'b0;
    step();
    checks++;
    if (obs !== c_fetch) begin errors++; $display("FAIL abort_refetch got=%h required=%h", obs, c_fetch); end
  endtask

  task automatic test_bad_funct();
    logic [19:0] e;
    op = 6'b000000; funct = 6'b111111;
    step();
    step();
    step();
    e = ev(4'd13, 3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL bad_funct_trap got=%h required=%h", obs, e); end
    do_reset();
  endtask

  task automatic test_ovf();
    logic [19:0] e;
    op = 6'b000000; funct = 6'b100000; of = 1'b1;
    step();
    step();
    e = ev(4'd3, 3'b100, 1'b1, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL ovf_exec got=%h required=%h", obs, e); end
    step();
    of = 1'b0;
`ifdef OVF_TRAP_EN
    e = ev(4'd13, 3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL ovf_trap got=%h required=%h", obs, e); end
    do_reset();
`else
    e = ev(4'd4, 3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 0, 0, 0, 1, 1, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL ovf_ignored got=%h required=%h", obs, e); end
    step();
`endif
  endtask

  task automatic test_trap();
    logic [19:0] e;
    op = 6'b111111;
    step();
    step();
    e = ev(4'd13, 3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs !== e) begin errors++; $display("FAIL trap_hold cycle=%0d got=%h required=%h", i, obs, e); end
      step();
    end
    rst = 1'b1;
    step();
    checks++;
    if (obs !== c_zero) begin errors++; $display("FAIL trap_reset got=%h required=%h", obs, c_zero); end
    rst = 1'b0;
    step();
    checks++;
    if (obs !== c_fetch) begin errors++; $display("FAIL trap_refetch got=%h required=%h", obs, c_fetch); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_lw_sw();
    test_branch();
    test_jump();
    test_reset_abort();
    test_bad_funct();
    test_ovf();
    wait_fetch();
    test_trap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
